fma16_arbiter: RTL and testbench
================================

# fma16_arbiter

Two-requester arbiter and sequencer for the shared half-precision FMA datapath (`fma16`).
- Accepts operations from two independent clients over valid/ready handshakes and grants one at a time, round-robin.
- Holds the winning operands stable on the core inputs for a fixed settle window, captures result and flags, and returns them to the winner over a response handshake.
- Sits between the client blocks and the purely combinational `fma16` core; the core is treated as a LAT-cycle multicycle path.

## Interface

Parameters
- LAT, 2: cycles the core inputs are held before capture (legal range 1..15).

Ports (index i ∈ {0,1} selects requester; vectors packed as {req1, req0})
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  requester i presents an operation.
- req_ready  out  2  operation from requester i accepted this cycle.
- req_x, req_y, req_z  in  32 each  operands, {op1[15:0], op0[15:0]}.
- req_ctrl  in  12  per requester {mul, add, negp, negz, roundmode[1:0]} = 6 bits.
- resp_valid  out  2  result pending for requester i.
- resp_ready  in  2  requester i consumes result.
- resp_result  out  16  captured result (shared bus, meaningful for the asserted resp_valid bit only).
- resp_flags  out  4  captured {invalid, overflow, underflow, inexact}.
- core_x, core_y, core_z  out  16 each  core operands.
- core_mul, core_add, core_negp, core_negz  out  1 each  core controls.
- core_roundmode  out  2  core rounding mode.
- core_result  in  16  core result.
- core_flags  in  4  core flags.
- busy  out  1  high in any state other than IDLE.

## Operation

- State machine: IDLE → EXEC → RESP → IDLE.
- IDLE
  - If any req_valid bit is set, choose a winner g: if both are set, g = ~last_grant; otherwise g is the sole requester.
  - req_ready[g] = 1 combinationally this cycle; the other bit is 0.
  - On the clock edge: register the operands and controls of g, set grant = g, last_grant = g, cnt = LAT-1, and move to EXEC.
- EXEC
  - core_* outputs are driven from the operand register, unchanged for the whole window.
  - cnt decrements each cycle.
  - In the cycle with cnt == 0: capture core_result and core_flags into the response registers and move to RESP.
- RESP
  - resp_valid[grant] = 1; the other bit is 0.
  - resp_result and resp_flags are held constant.
  - On resp_ready[grant] = 1: move to IDLE.
  - resp_ready on the non-granted bit is ignored.
- req_ready is 0 in EXEC and RESP. There is one outstanding operation at most; no new request is accepted in the same cycle as a response handshake.
- Core inputs keep their last registered value in IDLE and RESP. No input toggling occurs outside an accept edge.
- Clients must hold req_* stable while req_valid is high and not yet accepted. The arbiter makes no assumption beyond the accept cycle.
- A dropped req_valid before acceptance withdraws the request with no side effects.

## Timing

- Reset values
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie), grant = 0, cnt = 0.
  - Operand, result and flag registers = 0.
  - req_ready = 0, resp_valid = 0, busy = 0.
  - All core_* outputs = 0.
- Latency
  - Accept edge at cycle t; EXEC occupies cycles t+1 .. t+LAT; resp_valid rises at t+LAT+1.
  - With resp_ready held high, IDLE is re-entered at t+LAT+2.
  - Minimum issue interval per operation is LAT+2 cycles.
- Reset asserted mid-EXEC or mid-RESP
  - All state returns to reset values immediately (asynchronously).
  - The in-flight operation is discarded with no response.
  - The first accept after reset deassertion follows the rules above.
- cnt is 4 bits wide and never wraps, since LAT ≤ 15.
- Round-robin fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

## Test plan

- Single op, LAT=2: req0 sends x=0x3C00, y=0x4000, z=0x0000, mul=1, add=1, rm=RNE → req_ready[0] high in accept cycle; resp_valid[0] rises 3 cycles later; result=0x4000, flags=0x0.
- Simultaneous requests after reset: req0 sends 0x3C00·0x3C00+0x3C00, req1 sends 0x4000·0x4000+0x0000 → requester 0 is served first with 0x4000; requester 1 is served next with 0x4400; then requester 0 wins again if both are re-presented.
- Backpressure: hold resp_ready[1]=0 for 10 cycles → resp_valid[1] stays high; result and flags are stable; busy=1; req_ready=00; a new req0 is not accepted until the cycle after the handshake.
- Overflow flags: x=0x7BFF, y=0x7BFF, z=0, rm=RNE → result=0x7C00, flags=0b0101.
- Reset at second EXEC cycle → next cycle outputs are all at reset values; no resp_valid pulse for the killed op; the next request completes normally.
- LAT sweep 1, 4, 15: for each, the accept-to-resp_valid distance equals LAT+1; core_* outputs are checked to show no change during EXEC.

Source files
------------

// File: rtl/fma16_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the combinational fma16 core.
// Holds winning operands on the core for LAT cycles, captures the result, returns it to the winner.
module fma16_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic [31:0] req_z,
  input  logic [11:0] req_ctrl,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [15:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic [15:0] core_x,
  output logic [15:0] core_y,
  output logic [15:0] core_z,
  output logic        core_mul,
  output logic        core_add,
  output logic        core_negp,
  output logic        core_negz,
  output logic [1:0]  core_roundmode,
  input  logic [15:0] core_result,
  input  logic [3:0]  core_flags,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]  state;
  logic        last_grant;
  logic        grant;
  logic [3:0]  cnt;
  logic [15:0] op_x;
  logic [15:0] op_y;
  logic [15:0] op_z;
  logic [5:0]  op_ctrl;
  logic [15:0] res_q;
  logic [3:0]  flg_q;
  logic        win;
  logic        accept;

  // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
  // req_ready only rises in IDLE, resp_valid only in RESP, and each is one-hot on the winner.
  assign win    = (&req_valid) ? ~last_grant : req_valid[1];
  assign accept = (state == IDLE) && (|req_valid);

  assign req_ready  = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  assign core_x = op_x;
  assign core_y = op_y;
  assign core_z = op_z;
  assign {core_mul, core_add, core_negp, core_negz, core_roundmode} = op_ctrl;
  assign resp_result = res_q;
  assign resp_flags  = flg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      cnt        <= 4'd0;
      op_x       <= 16'd0;
      op_y       <= 16'd0;
      op_z       <= 16'd0;
      op_ctrl    <= 6'd0;
      res_q      <= 16'd0;
      flg_q      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_x       <= win ? req_x[31:16] : req_x[15:0];
            op_y       <= win ? req_y[31:16] : req_y[15:0];
            op_z       <= win ? req_z[31:16] : req_z[15:0];
            op_ctrl    <= win ? req_ctrl[11:6] : req_ctrl[5:0];
            grant      <= win;
            last_grant <= win;
            cnt        <= CNT_INIT;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // The core path is only trusted once the operands have been stable LAT cycles.
          if (cnt == 4'd0) begin
            res_q <= core_result;
            flg_q <= core_flags;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready[grant]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fma16_arbiter.sv
// Bench for fma16_arbiter: four instances (LAT 2,1,4,15) each driving a stand-in core,
// checked against a request-level arbitration model with an expected-response queue.
module tb_fma16_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_x, req_y, req_z;
  logic [11:0] req_ctrl;
  logic [1:0]  resp_ready;
  logic [3:0]  sel;

  logic [1:0]  rq_ready  [4];
  logic [1:0]  rs_valid  [4];
  logic [15:0] rs_result [4];
  logic [3:0]  rs_flags  [4];
  logic [15:0] cx [4];
  logic [15:0] cy [4];
  logic [15:0] cz [4];
  logic        cmul [4];
  logic        cadd [4];
  logic        cnegp [4];
  logic        cnegz [4];
  logic [1:0]  crm [4];
  logic [15:0] cres [4];
  logic [3:0]  cfl [4];
  logic        busy_a [4];
  logic [1:0]  dbg [4];

  int   cnt_total = 0;
  int   cnt_bad = 0;
  logic model_last = 1'b1;
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  // Stand-in for the fma16 core: true FMA results for the known vectors, a fixed scramble
  // otherwise so that mis-routed operands or controls produce a different result.
  function automatic logic [19:0] core_stub(input logic [15:0] x, y, z, input logic [5:0] c);
    logic [15:0] r;
    if (x == 16'h3C00 && y == 16'h4000 && z == 16'h0000) return {4'h0, 16'h4000};
    if (x == 16'h3C00 && y == 16'h3C00 && z == 16'h3C00) return {4'h0, 16'h4000};
    if (x == 16'h4000 && y == 16'h4000 && z == 16'h0000) return {4'h0, 16'h4400};
    if (x == 16'h7BFF && y == 16'h7BFF && z == 16'h0000) return {4'b0101, 16'h7C00};
    r = x ^ {y[7:0], y[15:8]} ^ {z[14:0], z[15]} ^ {10'd0, c};
    return {r[3:0] ^ c[3:0] ^ r[15:12], r};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 4 : 15;
  endfunction

  function automatic logic [53:0] core_bundle(input int k);
    return {cx[k], cy[k], cz[k], cmul[k], cadd[k], cnegp[k], cnegz[k], crm[k]};
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int L = (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 4 : 15;
    fma16_arbiter #(.LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & {2{sel[k]}}), .req_ready(rq_ready[k]),
      .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctrl(req_ctrl),
      .resp_valid(rs_valid[k]), .resp_ready(resp_ready),
      .resp_result(rs_result[k]), .resp_flags(rs_flags[k]),
      .core_x(cx[k]), .core_y(cy[k]), .core_z(cz[k]),
      .core_mul(cmul[k]), .core_add(cadd[k]), .core_negp(cnegp[k]), .core_negz(cnegz[k]),
      .core_roundmode(crm[k]), .core_result(cres[k]), .core_flags(cfl[k]),
      .busy(busy_a[k]), .dbg_state(dbg[k])
    );
    assign {cfl[k], cres[k]} = core_stub(cx[k], cy[k], cz[k],
                                         {cmul[k], cadd[k], cnegp[k], cnegz[k], crm[k]});
  end

  // ---------------- driver / monitor tasks ----------------
  task automatic present(input int i, input logic [15:0] x, y, z, input logic [5:0] c);
    req_x[i*16 +: 16]  = x;
    req_y[i*16 +: 16]  = y;
    req_z[i*16 +: 16]  = z;
    req_ctrl[i*6 +: 6] = c;
    req_valid[i]       = 1'b1;
  endtask

  task automatic new_op(output logic [15:0] x, y, z, output logic [5:0] c);
    case ($urandom_range(0, 5))
      0: begin x = 16'h3C00; y = 16'h4000; z = 16'h0000; end
      1: begin x = 16'h3C00; y = 16'h3C00; z = 16'h3C00; end
      2: begin x = 16'h4000; y = 16'h4000; z = 16'h0000; end
      3: begin x = 16'h7BFF; y = 16'h7BFF; z = 16'h0000; end
      default: begin
        x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
      end
    endcase
    c = 6'($urandom_range(0, 63));
  endtask

  // Called just after a negedge; n = cycles until resp_valid (1 = this cycle), -1 on timeout.
  task automatic wait_resp(input int k, output int n, output bit stable, output int rdy_seen);
    logic [53:0] snap;
    stable = 1'b1; rdy_seen = 0; n = -1; snap = '0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (i == 1) snap = core_bundle(k);
      else if (core_bundle(k) !== snap) stable = 1'b0;
      if (rq_ready[k] !== 2'b00) rdy_seen++;
      if (rs_valid[k] !== 2'b00) begin n = i; return; end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00; sel = 4'b0001;
    req_x = '0; req_y = '0; req_z = '0; req_ctrl = '0;
    repeat (3) @(negedge clk);
    #1;
    cnt_total++; if (rq_ready[0] !== 2'b00) begin cnt_bad++; $display("FAIL rst_req_ready: got %b want 00", rq_ready[0]); end
    cnt_total++; if (rs_valid[0] !== 2'b00) begin cnt_bad++; $display("FAIL rst_resp_valid: got %b want 00", rs_valid[0]); end
    cnt_total++; if (dbg[0] !== 2'd0) begin cnt_bad++; $display("FAIL rst_state: got %0d want 0", dbg[0]); end
    cnt_total++; if (core_bundle(0) !== 54'd0) begin cnt_bad++; $display("FAIL rst_core: got %h want 0", core_bundle(0)); end
    cnt_total++; if (rs_result[0] !== 16'd0) begin cnt_bad++; $display("FAIL rst_result: got %h want 0000", rs_result[0]); end
    cnt_total++; if (rs_flags[0] !== 4'd0) begin cnt_bad++; $display("FAIL rst_flags: got %h want 0", rs_flags[0]); end
    for (int k = 0; k < 4; k++) begin
      cnt_total++; if (busy_a[k] !== 1'b0) begin cnt_bad++; $display("FAIL rst_busy[%0d]: got %b want 0", k, busy_a[k]); end
    end
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_single();
    int n, rs; bit st;
    @(negedge clk);
    present(0, 16'h3C00, 16'h4000, 16'h0000, 6'b110000);
    #1;
    cnt_total++; if (rq_ready[0] !== 2'b01) begin cnt_bad++; $display("FAIL single_ready: got %b want 01", rq_ready[0]); end
    model_last = 1'b0;
    @(negedge clk); req_valid = 2'b00;
    wait_resp(0, n, st, rs);
    cnt_total++; if (n != 3) begin cnt_bad++; $display("FAIL single_latency: got %0d want 3", n); end
    cnt_total++; if (st !== 1'b1) begin cnt_bad++; $display("FAIL single_core_stable: got %b want 1", st); end
    cnt_total++; if (rs_valid[0] !== 2'b01) begin cnt_bad++; $display("FAIL single_resp_valid: got %b want 01", rs_valid[0]); end
    cnt_total++; if (rs_result[0] !== 16'h4000) begin cnt_bad++; $display("FAIL single_result: got %h want 4000", rs_result[0]); end
    cnt_total++; if (rs_flags[0] !== 4'h0) begin cnt_bad++; $display("FAIL single_flags: got %h want 0", rs_flags[0]); end
    cnt_total++; if (core_bundle(0) !== {16'h3C00, 16'h4000, 16'h0000, 6'b110000}) begin cnt_bad++; $display("FAIL single_core_ops: got %h", core_bundle(0)); end
    cnt_total++; if (busy_a[0] !== 1'b1) begin cnt_bad++; $display("FAIL single_busy: got %b want 1", busy_a[0]); end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00; #1;
    cnt_total++; if (busy_a[0] !== 1'b0) begin cnt_bad++; $display("FAIL single_idle: got %b want 0", busy_a[0]); end
    cnt_total++; if (rs_valid[0] !== 2'b00) begin cnt_bad++; $display("FAIL single_resp_drop: got %b want 00", rs_valid[0]); end
  endtask

  task automatic test_tie();
    int n, rs; bit st;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; model_last = 1'b1;
    present(0, 16'h3C00, 16'h3C00, 16'h3C00, 6'b110000);
    present(1, 16'h4000, 16'h4000, 16'h0000, 6'b110000);
    #1;
    cnt_total++; if (rq_ready[0] !== 2'b01) begin cnt_bad++; $display("FAIL tie_first_ready: got %b want 01", rq_ready[0]); end
    model_last = 1'b0;
    @(negedge clk); req_valid[0] = 1'b0;
    wait_resp(0, n, st, rs);
    cnt_total++; if (rs_valid[0] !== 2'b01 || rs_result[0] !== 16'h4000) begin cnt_bad++; $display("FAIL tie_resp0: got valid %b result %h want 01 4000", rs_valid[0], rs_result[0]); end
    cnt_total++; if (rs != 0) begin cnt_bad++; $display("FAIL tie_ready_while_busy: got %0d cycles want 0", rs); end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00; #1;
    cnt_total++; if (rq_ready[0] !== 2'b10) begin cnt_bad++; $display("FAIL tie_second_ready: got %b want 10", rq_ready[0]); end
    model_last = 1'b1;
    @(negedge clk); req_valid[1] = 1'b0;
    wait_resp(0, n, st, rs);
    cnt_total++; if (rs_valid[0] !== 2'b10 || rs_result[0] !== 16'h4400) begin cnt_bad++; $display("FAIL tie_resp1: got valid %b result %h want 10 4400", rs_valid[0], rs_result[0]); end
    present(0, 16'h3C00, 16'h4000, 16'h0000, 6'b110000);
    present(1, 16'h4000, 16'h4000, 16'h0000, 6'b110000);
    resp_ready = 2'b10;
    @(negedge clk); resp_ready = 2'b00; #1;
    cnt_total++; if (rq_ready[0] !== 2'b01) begin cnt_bad++; $display("FAIL tie_third_ready: got %b want 01", rq_ready[0]); end
    model_last = 1'b0;
    // Requester 1 withdraws before ever being accepted.
    @(negedge clk); req_valid = 2'b00;
    wait_resp(0, n, st, rs);
    cnt_total++; if (rs_valid[0] !== 2'b01 || rs_result[0] !== 16'h4000) begin cnt_bad++; $display("FAIL tie_resp0b: got valid %b result %h want 01 4000", rs_valid[0], rs_result[0]); end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00;
    @(negedge clk); #1;
    cnt_total++; if (busy_a[0] !== 1'b0) begin cnt_bad++; $display("FAIL tie_withdraw_idle: got %b want 0", busy_a[0]); end
  endtask

  task automatic test_backpressure();
    int n, rs; bit st;
    logic [15:0] x1, y1, z1, x0, y0, z0;
    logic [5:0] c1, c0;
    logic [19:0] e1, e0;
    new_op(x1, y1, z1, c1); new_op(x0, y0, z0, c0);
    e1 = core_stub(x1, y1, z1, c1); e0 = core_stub(x0, y0, z0, c0);
    @(negedge clk);
    present(1, x1, y1, z1, c1); #1;
    cnt_total++; if (rq_ready[0] !== 2'b10) begin cnt_bad++; $display("FAIL bp_ready1: got %b want 10", rq_ready[0]); end
    model_last = 1'b1;
    @(negedge clk); req_valid[1] = 1'b0;
    present(0, x0, y0, z0, c0);
    wait_resp(0, n, st, rs);
    cnt_total++; if (rs != 0) begin cnt_bad++; $display("FAIL bp_exec_ready: got %0d cycles want 0", rs); end
    resp_ready = 2'b01;  // only the non-granted bit: must be ignored
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      cnt_total++; if (rs_valid[0] !== 2'b10) begin cnt_bad++; $display("FAIL bp_valid c%0d: got %b want 10", i, rs_valid[0]); end
      cnt_total++; if ({rs_flags[0], rs_result[0]} !== e1) begin cnt_bad++; $display("FAIL bp_data c%0d: got %h want %h", i, {rs_flags[0], rs_result[0]}, e1); end
      cnt_total++; if (busy_a[0] !== 1'b1) begin cnt_bad++; $display("FAIL bp_busy c%0d: got %b want 1", i, busy_a[0]); end
      cnt_total++; if (rq_ready[0] !== 2'b00) begin cnt_bad++; $display("FAIL bp_req_ready c%0d: got %b want 00", i, rq_ready[0]); end
    end
    resp_ready = 2'b10; #1;
    cnt_total++; if (rq_ready[0] !== 2'b00) begin cnt_bad++; $display("FAIL bp_handshake_ready: got %b want 00", rq_ready[0]); end
    @(negedge clk); resp_ready = 2'b00; #1;
    cnt_total++; if (rq_ready[0] !== 2'b01) begin cnt_bad++; $display("FAIL bp_after_ready: got %b want 01", rq_ready[0]); end
    model_last = 1'b0;
    @(negedge clk); req_valid = 2'b00;
    wait_resp(0, n, st, rs);
    cnt_total++; if (rs_valid[0] !== 2'b01 || {rs_flags[0], rs_result[0]} !== e0) begin cnt_bad++; $display("FAIL bp_resp0: got %b %h want 01 %h", rs_valid[0], {rs_flags[0], rs_result[0]}, e0); end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  task automatic test_overflow();
    int n, rs; bit st;
    @(negedge clk);
    present(0, 16'h7BFF, 16'h7BFF, 16'h0000, 6'b110000); #1;
    cnt_total++; if (rq_ready[0] !== 2'b01) begin cnt_bad++; $display("FAIL ovf_ready: got %b want 01", rq_ready[0]); end
    model_last = 1'b0;
    @(negedge clk); req_valid = 2'b00;
    wait_resp(0, n, st, rs);
    cnt_total++; if (rs_result[0] !== 16'h7C00) begin cnt_bad++; $display("FAIL ovf_result: got %h want 7c00", rs_result[0]); end
    cnt_total++; if (rs_flags[0] !== 4'b0101) begin cnt_bad++; $display("FAIL ovf_flags: got %b want 0101", rs_flags[0]); end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    int n, rs, seen; bit st;
    logic [15:0] x, y, z; logic [5:0] c;
    new_op(x, y, z, c);
    @(negedge clk);
    present(1, x, y, z, c);
    @(negedge clk); req_valid = 2'b00;   // first EXEC cycle
    @(negedge clk); reset = 1'b1; #1;    // second EXEC cycle
    cnt_total++; if (busy_a[0] !== 1'b0 || dbg[0] !== 2'd0) begin cnt_bad++; $display("FAIL midrst_state: got busy %b state %0d want 0 0", busy_a[0], dbg[0]); end
    cnt_total++; if (core_bundle(0) !== 54'd0) begin cnt_bad++; $display("FAIL midrst_core: got %h want 0", core_bundle(0)); end
    cnt_total++; if (rs_valid[0] !== 2'b00) begin cnt_bad++; $display("FAIL midrst_resp_valid: got %b want 00", rs_valid[0]); end
    @(negedge clk); reset = 1'b0; model_last = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1; if (rs_valid[0] !== 2'b00) seen++;
      @(negedge clk);
    end
    cnt_total++; if (seen != 0) begin cnt_bad++; $display("FAIL midrst_no_resp: got %0d pulses want 0", seen); end
    present(0, 16'h3C00, 16'h4000, 16'h0000, 6'b110000);
    present(1, x, y, z, c); #1;
    cnt_total++; if (rq_ready[0] !== 2'b01) begin cnt_bad++; $display("FAIL midrst_tie: got %b want 01", rq_ready[0]); end
    model_last = 1'b0;
    @(negedge clk); req_valid = 2'b00;
    wait_resp(0, n, st, rs);
    cnt_total++; if (n != 3 || rs_result[0] !== 16'h4000) begin cnt_bad++; $display("FAIL midrst_next_op: got lat %0d result %h want 3 4000", n, rs_result[0]); end
    resp_ready = 2'b01;
    @(negedge clk); resp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    int n, rs; bit st;
    logic g;
    logic [19:0] e [2];
    e[0] = core_stub(16'h1234, 16'h5678, 16'h9ABC, 6'h2A);
    e[1] = core_stub(16'h0F0F, 16'hF00F, 16'h3333, 6'h15);
    @(negedge clk);
    present(0, 16'h1234, 16'h5678, 16'h9ABC, 6'h2A);
    present(1, 16'h0F0F, 16'hF00F, 16'h3333, 6'h15);
    resp_ready = 2'b11;
    for (int j = 0; j < 6; j++) begin
      g = ~model_last; model_last = g;
      wait_resp(0, n, st, rs);
      cnt_total++; if (n != 4) begin cnt_bad++; $display("FAIL b2b_interval %0d: got %0d want 4", j, n); end
      cnt_total++; if (rs_valid[0] !== (g ? 2'b10 : 2'b01) || {rs_flags[0], rs_result[0]} !== e[g]) begin
        cnt_bad++; $display("FAIL b2b_grant %0d: got %b %h want %b %h", j, rs_valid[0], {rs_flags[0], rs_result[0]}, (g ? 2'b10 : 2'b01), e[g]);
      end
      if (j == 5) req_valid = 2'b00;
      @(negedge clk);
    end
    resp_ready = 2'b00; #1;
    cnt_total++; if (busy_a[0] !== 1'b0) begin cnt_bad++; $display("FAIL b2b_idle: got %b want 0", busy_a[0]); end
  endtask

  task automatic test_random();
    logic pend [2];
    logic [15:0] ox [2];
    logic [15:0] oy [2];
    logic [15:0] oz [2];
    logic [5:0] oc [2];
    logic [20:0] e;
    logic g;
    int n, rs, j; bit st;
    pend[0] = 1'b0; pend[1] = 1'b0;
    @(negedge clk);
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          new_op(ox[i], oy[i], oz[i], oc[i]); present(i, ox[i], oy[i], oz[i], oc[i]); pend[i] = 1'b1;
        end
      if (!pend[0] && !pend[1]) begin
        j = $urandom_range(0, 1);
        new_op(ox[j], oy[j], oz[j], oc[j]); present(j, ox[j], oy[j], oz[j], oc[j]); pend[j] = 1'b1;
      end
      g = (pend[0] && pend[1]) ? ~model_last : pend[1];
      model_last = g;
      exp_q.push_back({g, core_stub(ox[g], oy[g], oz[g], oc[g])});
      #1;
      cnt_total++; if (rq_ready[0] !== (g ? 2'b10 : 2'b01)) begin cnt_bad++; $display("FAIL rr_ready t%0d: got %b want %b", t, rq_ready[0], (g ? 2'b10 : 2'b01)); end
      @(negedge clk); req_valid[g] = 1'b0; pend[g] = 1'b0;
      wait_resp(0, n, st, rs);
      e = exp_q.pop_front();
      cnt_total++; if (n != 3 || rs != 0) begin cnt_bad++; $display("FAIL rr_timing t%0d: got lat %0d ready %0d want 3 0", t, n, rs); end
      cnt_total++; if (rs_valid[0] !== (e[20] ? 2'b10 : 2'b01) || {rs_flags[0], rs_result[0]} !== e[19:0]) begin
        cnt_bad++; $display("FAIL rr_resp t%0d: got %b %h want %b %h", t, rs_valid[0], {rs_flags[0], rs_result[0]}, (e[20] ? 2'b10 : 2'b01), e[19:0]);
      end
      resp_ready = 2'b00; resp_ready[~g] = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk); #1;
        cnt_total++; if (rs_valid[0] !== (e[20] ? 2'b10 : 2'b01) || {rs_flags[0], rs_result[0]} !== e[19:0]) begin
          cnt_bad++; $display("FAIL rr_hold t%0d: got %b %h want %h", t, rs_valid[0], {rs_flags[0], rs_result[0]}, e[19:0]);
        end
      end
      resp_ready = 2'b00; resp_ready[g] = 1'b1;
      @(negedge clk); resp_ready = 2'b00; #1;
      cnt_total++; if (rs_valid[0] !== 2'b00) begin cnt_bad++; $display("FAIL rr_release t%0d: got %b want 00", t, rs_valid[0]); end
    end
    req_valid = 2'b00;
    @(negedge clk); #1;
    cnt_total++; if (busy_a[0] !== 1'b0) begin cnt_bad++; $display("FAIL rr_idle: got %b want 0", busy_a[0]); end
  endtask

  task automatic test_lat_sweep();
    int n, rs; bit st;
    logic [15:0] x, y, z; logic [5:0] c;
    logic [19:0] e;
    for (int k = 1; k < 4; k++) begin
      sel = 4'(1 << k);
      new_op(x, y, z, c); e = core_stub(x, y, z, c);
      @(negedge clk);
      present(0, x, y, z, c); #1;
      cnt_total++; if (rq_ready[k] !== 2'b01) begin cnt_bad++; $display("FAIL sweep_ready lat%0d: got %b want 01", lat_of(k), rq_ready[k]); end
      @(negedge clk); req_valid = 2'b00;
      wait_resp(k, n, st, rs);
      cnt_total++; if (n != lat_of(k) + 1) begin cnt_bad++; $display("FAIL sweep_latency lat%0d: got %0d want %0d", lat_of(k), n, lat_of(k) + 1); end
      cnt_total++; if (st !== 1'b1) begin cnt_bad++; $display("FAIL sweep_core_stable lat%0d: got %b want 1", lat_of(k), st); end
      cnt_total++; if ({rs_flags[k], rs_result[k]} !== e) begin cnt_bad++; $display("FAIL sweep_result lat%0d: got %h want %h", lat_of(k), {rs_flags[k], rs_result[k]}, e); end
      resp_ready = 2'b01;
      @(negedge clk); resp_ready = 2'b00; #1;
      cnt_total++; if (busy_a[k] !== 1'b0) begin cnt_bad++; $display("FAIL sweep_idle lat%0d: got %b want 0", lat_of(k), busy_a[k]); end
    end
    sel = 4'b0001;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_lat_sweep();
    $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
    $finish;
  end

endmodule
